regfile_mp: RTL and testbench
=============================

// Module: regfile_mp
// PURPOSE
//  Parametrised multi-port register file for the miniRISC datapath: NUM_RD async read ports, two write ports.
//  Adds optional write-to-read bypass, optional hardwired-zero register 0, and a sequenced soft-clear engine.
//  Sits between decode (read ports) and writeback (write ports); replaces the fixed 32x32 2R1W file.
// PARAMETERS
//  DATA_W    32  register width in bits
//  ADDR_W    5   address width; DEPTH = 2**ADDR_W registers
//  NUM_RD    2   number of read ports (1..4)
//  ZERO_REG  1   1: reg 0 always reads 0, writes to it are dropped
//  BYPASS    1   1: read of an address written this cycle returns the incoming write data
// PORTS
//  clk       in   1               rising-edge clock
//  rst_n     in   1               async active-low reset
//  rd_addr   in   NUM_RD*ADDR_W   read addresses, port i at [i*ADDR_W +: ADDR_W]
//  rd_data   out  NUM_RD*DATA_W   read data, port i at [i*DATA_W +: DATA_W]
//  wr0_en    in   1               write port 0 enable
//  wr0_addr  in   ADDR_W          write port 0 address
//  wr0_data  in   DATA_W          write port 0 data
//  wr1_en    in   1               write port 1 enable (priority over port 0)
//  wr1_addr  in   ADDR_W          write port 1 address
//  wr1_data  in   DATA_W          write port 1 data
//  clr_req   in   1               soft-clear request, sampled in IDLE only
//  busy      out  1               clear in progress; writes are ignored
//  clr_done  out  1               one-cycle pulse after the last register is cleared
// BEHAVIOUR
//  Reset (rst_n=0, async): all DEPTH regs <= 0, FSM -> IDLE, clr_ptr <= 0, busy=0, clr_done=0.
//  Reads: combinational, zero latency. rd_data = reg[rd_addr], except:
//   - ZERO_REG=1 and rd_addr==0 -> 0 (overrides bypass).
//   - BYPASS=1, not busy, wr1_en and wr1_addr==rd_addr -> wr1_data; else same for port 0 -> wr0_data.
//   - BYPASS=0 -> old value until the next clock edge.
//  Writes: on posedge clk in IDLE. wr0/wr1 to different addresses both commit.
//   Same address, both enabled -> wr1_data commits; wr0 is dropped. ZERO_REG=1: writes to addr 0 are dropped.
//  FSM: states IDLE, CLEAR, DONE (2-bit encoding).
//   IDLE:  clr_req=1 -> CLEAR, clr_ptr <= 0, busy <= 1. Writes in that same cycle still commit.
//   CLEAR: reg[clr_ptr] <= 0, clr_ptr++ each cycle. All write ports ignored.
//          clr_ptr == DEPTH-1 -> DONE. Total = DEPTH cycles with busy=1.
//   DONE:  clr_done=1 for one cycle, busy=0, -> IDLE. Writes are accepted in DONE.
//  clr_req asserted during CLEAR/DONE: ignored; not queued.
//  Reads during CLEAR: return current array contents (partially cleared); bypass disabled.
//  rst_n asserted mid-clear: immediate full zeroing, FSM -> IDLE, no clr_done pulse.
//  clr_ptr is ADDR_W bits wide; wrap never occurs because the FSM exits at DEPTH-1.
//  busy and clr_done are registered outputs, with no combinational path from inputs.
// STRUCTURE
//  Shared package regfile_pkg: FSM state localparams (S_IDLE, S_CLEAR, S_DONE) and
//   default widths (RF_DATA_W=32, RF_ADDR_W=5) used by decode/writeback.
//  Sub-module rf_read_port: one read mux, including zero and bypass logic.
//   Instantiated NUM_RD times in a generate loop.
//  Array, write-priority logic and clear FSM are kept in regfile_mp.
// TESTING
//  1 Reset: drive rst_n=0 mid-cycle, then release -> all 32 regs read 0 on every port; busy=0.
//  2 Write/read: wr0 r5=0xDEADBEEF, next cycle rd_addr0=5 -> 0xDEADBEEF. r0 write 0x1234 -> reads 0 (ZERO_REG=1).
//  3 Collision: wr0 r7=0x11, wr1 r7=0x22 same cycle -> r7=0x22. wr0 r8=0x33 with wr1 r9=0x44 -> both commit.
//  4 Bypass: wr1 r3=0xA5A5, rd_addr1=3 same cycle -> 0xA5A5 combinationally.
//    BYPASS=0 build -> old value, then 0xA5A5 after the edge.
//  5 Soft clear: preload r1..r31=idx; pulse clr_req -> busy high exactly 32 cycles, clr_done one pulse.
//    All regs read 0 afterwards. wr0 r4=0x99 during CLEAR -> dropped, r4 stays 0.
//  6 Reset mid-clear: rst_n=0 at clr_ptr=10 -> all regs 0, busy=0 immediately, no clr_done.
//    clr_req after release restarts from ptr 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the miniRISC register file: default widths used by
// decode/writeback and the soft-clear sequencer state encoding.
package regfile_pkg;

   localparam int RF_DATA_W = 32;
   localparam int RF_ADDR_W = 5;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CLEAR = 2'd1,
      S_DONE  = 2'd2
   } rfState_e;

endpackage

// File: rtl/regfile_mp_read_port.sv
// One combinational read port: array select, same-cycle write bypass and
// hardwired-zero register 0 (which overrides the bypass).
module rf_read_port
   import regfile_pkg::*;
#(
   parameter int DATA_W   = RF_DATA_W,
   parameter int ADDR_W   = RF_ADDR_W,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
)(
   input  logic [(2**ADDR_W)-1:0][DATA_W-1:0] regArr,
   input  logic [ADDR_W-1:0]                  rdAddr,
   input  logic                               bypassEn,
   input  logic                               wr0En,
   input  logic [ADDR_W-1:0]                  wr0Addr,
   input  logic [DATA_W-1:0]                  wr0Data,
   input  logic                               wr1En,
   input  logic [ADDR_W-1:0]                  wr1Addr,
   input  logic [DATA_W-1:0]                  wr1Data,
   output logic [DATA_W-1:0]                  rdData
);

   always_comb begin
      rdData = regArr[rdAddr];
      // Port 1 is checked first so the bypass matches the write priority.
      if ((BYPASS != 0) && bypassEn) begin
         if (wr1En && (wr1Addr == rdAddr)) begin
            rdData = wr1Data;
         end else if (wr0En && (wr0Addr == rdAddr)) begin
            rdData = wr0Data;
         end
      end
      if ((ZERO_REG != 0) && (rdAddr == '0)) begin
         rdData = '0;
      end
   end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD async read ports, two prioritised write
// ports and a one-register-per-cycle soft-clear sequencer.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int DATA_W   = RF_DATA_W,
   parameter int ADDR_W   = RF_ADDR_W,
   parameter int NUM_RD   = 2,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
)(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   input  logic                     wr0_en,
   input  logic [ADDR_W-1:0]        wr0_addr,
   input  logic [DATA_W-1:0]        wr0_data,
   input  logic                     wr1_en,
   input  logic [ADDR_W-1:0]        wr1_addr,
   input  logic [DATA_W-1:0]        wr1_data,
   input  logic                     clr_req,
   output logic                     busy,
   output logic                     clr_done
);

   localparam int DEPTH = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W-1:0] PTR_STEP = ADDR_W'(1);

   rfState_e                     state;
   logic [ADDR_W-1:0]            clrPtr;
   logic [DEPTH-1:0][DATA_W-1:0] regArr;
   logic                         writeOpen;
   logic                         wr0Commit;
   logic                         wr1Commit;

   assign writeOpen = (state != S_CLEAR);
   assign wr0Commit = writeOpen && wr0_en && !((ZERO_REG != 0) && (wr0_addr == '0));
   assign wr1Commit = writeOpen && wr1_en && !((ZERO_REG != 0) && (wr1_addr == '0));

   // Clear sequencer: busy covers exactly the DEPTH clearing cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         clrPtr   <= '0;
         busy     <= 1'b0;
         clr_done <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               clr_done <= 1'b0;
               if (clr_req) begin
                  state  <= S_CLEAR;
                  clrPtr <= '0;
                  busy   <= 1'b1;
               end
            end
            S_CLEAR: begin
               if (clrPtr == LAST_PTR) begin
                  state    <= S_DONE;
                  busy     <= 1'b0;
                  clr_done <= 1'b1;
               end else begin
                  clrPtr <= clrPtr + PTR_STEP;
               end
            end
            S_DONE: begin
               state    <= S_IDLE;
               clr_done <= 1'b0;
            end
            default: begin
               state    <= S_IDLE;
               busy     <= 1'b0;
               clr_done <= 1'b0;
            end
         endcase
      end
   end

   // Port 1 is assigned last so it wins a same-address collision.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         regArr <= '0;
      end else if (state == S_CLEAR) begin
         regArr[clrPtr] <= '0;
      end else begin
         if (wr0Commit) begin
            regArr[wr0_addr] <= wr0_data;
         end
         if (wr1Commit) begin
            regArr[wr1_addr] <= wr1_data;
         end
      end
   end

   for (genvar i = 0; i < NUM_RD; i++) begin : gRdPort
      rf_read_port #(
         .DATA_W   (DATA_W),
         .ADDR_W   (ADDR_W),
         .ZERO_REG (ZERO_REG),
         .BYPASS   (BYPASS)
      ) uRdPort (
         .regArr   (regArr),
         .rdAddr   (rd_addr[i*ADDR_W +: ADDR_W]),
         .bypassEn (writeOpen),
         .wr0En    (wr0_en),
         .wr0Addr  (wr0_addr),
         .wr0Data  (wr0_data),
         .wr1En    (wr1_en),
         .wr1Addr  (wr1_addr),
         .wr1Data  (wr1_data),
         .rdData   (rd_data[i*DATA_W +: DATA_W])
      );
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a default build (zero reg, bypass) and a plain build
// (no zero reg, no bypass) share stimulus and are checked against a model.
module tb_regfile_mp;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [9:0]  rdAddr;
   logic [63:0] rdDataA, rdDataB;
   logic        wr0En, wr1En, clrReq;
   logic [4:0]  wr0Addr, wr1Addr;
   logic [31:0] wr0Data, wr1Data;
   logic        busyA, busyB, doneA, doneB;

   int nCmp = 0;
   int nMis = 0;
   bit checkEn = 1'b0;

   logic [31:0] mA [32];
   logic [31:0] mB [32];
   int          clrIdx = -1;
   bit          donePend = 1'b0;

   always #5 clk = ~clk;

   regfile_mp dutA (
      .clk(clk), .rst_n(rst_n), .rd_addr(rdAddr), .rd_data(rdDataA),
      .wr0_en(wr0En), .wr0_addr(wr0Addr), .wr0_data(wr0Data),
      .wr1_en(wr1En), .wr1_addr(wr1Addr), .wr1_data(wr1Data),
      .clr_req(clrReq), .busy(busyA), .clr_done(doneA)
   );

   regfile_mp #(.ZERO_REG(0), .BYPASS(0)) dutB (
      .clk(clk), .rst_n(rst_n), .rd_addr(rdAddr), .rd_data(rdDataB),
      .wr0_en(wr0En), .wr0_addr(wr0Addr), .wr0_data(wr0Data),
      .wr1_en(wr1En), .wr1_addr(wr1Addr), .wr1_data(wr1Data),
      .clr_req(clrReq), .busy(busyB), .clr_done(doneB)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nCmp++;
      if (act !== exp) begin
         nMis++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic setRd(input int p, input logic [4:0] a);
      rdAddr[p*5 +: 5] = a;
   endtask

   function automatic logic [31:0] portA(input int p);
      return rdDataA[p*32 +: 32];
   endfunction

   function automatic logic [31:0] portB(input int p);
      return rdDataB[p*32 +: 32];
   endfunction

   // Expected read value from the architectural rules.
   function automatic logic [31:0] expRd(input bit zeroReg, input bit byp, input logic [4:0] a);
      logic [31:0] v;
      v = zeroReg ? mA[a] : mB[a];
      if (byp && clrIdx < 0) begin
         if (wr1En && wr1Addr == a) v = wr1Data;
         else if (wr0En && wr0Addr == a) v = wr0Data;
      end
      if (zeroReg && a == 5'd0) v = '0;
      return v;
   endfunction

   initial begin
      forever begin
         @(negedge rst_n);
         for (int i = 0; i < 32; i++) begin
            mA[i] = '0;
            mB[i] = '0;
         end
         clrIdx   = -1;
         donePend = 1'b0;
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         if (rst_n) begin
            if (clrIdx >= 0) begin
               mA[clrIdx] = '0;
               mB[clrIdx] = '0;
               clrIdx++;
               if (clrIdx == 32) begin
                  clrIdx   = -1;
                  donePend = 1'b1;
               end
            end else begin
               if (wr0En && wr0Addr != 5'd0) mA[wr0Addr] = wr0Data;
               if (wr1En && wr1Addr != 5'd0) mA[wr1Addr] = wr1Data;
               if (wr0En) mB[wr0Addr] = wr0Data;
               if (wr1En) mB[wr1Addr] = wr1Data;
               if (donePend) donePend = 1'b0;
               else if (clrReq) clrIdx = 0;
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (checkEn) begin
            for (int p = 0; p < 2; p++) begin
               chk($sformatf("rdA%0d", p), portA(p), expRd(1'b1, 1'b1, rdAddr[p*5 +: 5]));
               chk($sformatf("rdB%0d", p), portB(p), expRd(1'b0, 1'b0, rdAddr[p*5 +: 5]));
            end
            chk("busyA", 32'(busyA), 32'(clrIdx >= 0));
            chk("busyB", 32'(busyB), 32'(clrIdx >= 0));
            chk("doneA", 32'(doneA), 32'(donePend));
            chk("doneB", 32'(doneB), 32'(donePend));
         end
      end
   end

   task automatic runClear(input bit probeWrite, output int busyCnt, output int doneCnt);
      clrReq = 1'b1;
      cyc();
      clrReq = 1'b0;
      busyCnt = 0;
      doneCnt = 0;
      for (int i = 0; i < 60; i++) begin
         #2;
         if (busyA) busyCnt++;
         if (doneA) doneCnt++;
         if (probeWrite && i == 5) begin
            wr0En = 1'b1; wr0Addr = 5'd4; wr0Data = 32'h99;
         end
         if (i == 6) wr0En = 1'b0;
         cyc();
      end
   endtask

   initial begin
      int bc, dc;
      rdAddr = '0; wr0En = 0; wr1En = 0; clrReq = 0;
      wr0Addr = '0; wr1Addr = '0; wr0Data = '0; wr1Data = '0;

      // Reset asserted mid-cycle
      repeat (2) cyc();
      rst_n = 1'b0;
      #1 checkEn = 1'b1;
      chk("rstBusy", 32'(busyA), 32'd0);
      chk("rstDone", 32'(doneA), 32'd0);
      cyc(); cyc();
      rst_n = 1'b1;
      for (int a = 0; a < 32; a++) begin
         setRd(0, 5'(a));
         setRd(1, 5'(31 - a));
         #1;
         chk("rstRd0", portA(0), 32'd0);
         chk("rstRd1", portA(1), 32'd0);
         chk("rstRdB", portB(0), 32'd0);
      end
      cyc();

      // Basic write then read, and register 0
      wr0En = 1; wr0Addr = 5'd5; wr0Data = 32'hDEADBEEF;
      cyc();
      wr0En = 0; setRd(0, 5'd5);
      #2 chk("wrRdA", portA(0), 32'hDEADBEEF);
      chk("wrRdB", portB(0), 32'hDEADBEEF);
      wr0En = 1; wr0Addr = 5'd0; wr0Data = 32'h1234;
      cyc();
      wr0En = 0; setRd(0, 5'd0);
      #2 chk("zeroA", portA(0), 32'd0);
      chk("zeroB", portB(0), 32'h1234);
      cyc();

      // Write collisions
      wr0En = 1; wr0Addr = 5'd7; wr0Data = 32'h11;
      wr1En = 1; wr1Addr = 5'd7; wr1Data = 32'h22;
      cyc();
      wr0Addr = 5'd8; wr0Data = 32'h33;
      wr1Addr = 5'd9; wr1Data = 32'h44;
      cyc();
      wr0En = 0; wr1En = 0;
      setRd(0, 5'd7); setRd(1, 5'd8);
      #2 chk("collide", portA(0), 32'h22);
      chk("pair0", portA(1), 32'h33);
      setRd(0, 5'd9);
      #1 chk("pair1", portA(0), 32'h44);
      cyc();

      // Bypass vs. no bypass
      setRd(1, 5'd3);
      wr1En = 1; wr1Addr = 5'd3; wr1Data = 32'hA5A5;
      #2 chk("bypA", portA(1), 32'hA5A5);
      chk("bypBold", portB(1), 32'd0);
      cyc();
      wr1En = 0;
      #2 chk("bypBnew", portB(1), 32'hA5A5);
      chk("bypAnew", portA(1), 32'hA5A5);
      cyc();

      // Soft clear of a preloaded file, with a write attempted mid-clear
      for (int a = 1; a < 32; a++) begin
         wr0En = 1; wr0Addr = 5'(a); wr0Data = 32'(a);
         cyc();
      end
      wr0En = 0;
      setRd(0, 5'd17);
      #2 chk("preload", portA(0), 32'd17);
      cyc();
      setRd(0, 5'd4); setRd(1, 5'd10);
      runClear(1'b1, bc, dc);
      chk("busyLen", 32'(bc), 32'd32);
      chk("donePulse", 32'(dc), 32'd1);
      for (int a = 0; a < 32; a++) begin
         setRd(0, 5'(a));
         #1 chk("cleared", portA(0), 32'd0);
         chk("clearedB", portB(0), 32'd0);
      end
      setRd(0, 5'd4);
      #1 chk("r4dropped", portA(0), 32'd0);
      cyc();

      // Reset in the middle of a clear
      for (int a = 1; a < 32; a++) begin
         wr0En = 1; wr0Addr = 5'(a); wr0Data = 32'(a + 256);
         cyc();
      end
      wr0En = 0;
      clrReq = 1;
      cyc();
      clrReq = 0;
      repeat (10) cyc();
      rst_n = 1'b0;
      #1 chk("midBusy", 32'(busyA), 32'd0);
      chk("midDone", 32'(doneA), 32'd0);
      setRd(0, 5'd20);
      #1 chk("midZero", portA(0), 32'd0);
      cyc();
      rst_n = 1'b1;
      dc = 0;
      for (int i = 0; i < 40; i++) begin
         #2 if (doneA) dc++;
         cyc();
      end
      chk("noDone", 32'(dc), 32'd0);
      wr0En = 1; wr0Addr = 5'd0 + 5'd31; wr0Data = 32'h7777;
      cyc();
      wr0En = 0;
      runClear(1'b0, bc, dc);
      chk("restartLen", 32'(bc), 32'd32);
      chk("restartDone", 32'(dc), 32'd1);

      // Randomised traffic
      for (int n = 0; n < 1500; n++) begin
         wr0En   = 1'($urandom_range(0, 1));
         wr1En   = 1'($urandom_range(0, 1));
         wr0Addr = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
         wr1Addr = ($urandom_range(0, 3) == 0) ? wr0Addr : 5'($urandom);
         wr0Data = $urandom;
         wr1Data = $urandom;
         setRd(0, ($urandom_range(0, 2) == 0) ? wr0Addr : 5'($urandom));
         setRd(1, ($urandom_range(0, 2) == 0) ? wr1Addr : 5'($urandom));
         clrReq  = ($urandom_range(0, 59) == 0);
         cyc();
      end
      wr0En = 0; wr1En = 0; clrReq = 0;
      repeat (40) cyc();
      checkEn = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nMis);
      $finish;
   end

endmodule
